// File: rtl/spi_wb_bridge_rw_pkg.sv
// Shared constants and state encodings for the SPI-to-Wishbone bridge.
`timescale 1ns/1ps
package spi_wb_bridge_rw_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RD_FILL   = 8'hEE;

    typedef enum logic [2:0] {
        F_CMD    = 3'd0,
        F_ADDR   = 3'd1,
        F_WDATA  = 3'd2,
        F_DUMMY  = 3'd3,
        F_RDATA  = 3'd4,
        F_IGNORE = 3'd5
    } frame_state_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_READ  = 2'd2
    } wb_state_t;

    // Even parity of a byte, kept for integrity checks on the data path.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/spi_wb_bridge_rw_shifter.sv
// SPI mode-0 slave shifter: input synchronisers, sclk edge detection,
// bit counting, RX byte assembly and TX shift register driving MISO.
`timescale 1ns/1ps
module spi_wb_bridge_rw_shifter
    import spi_wb_bridge_rw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       cs_active,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    logic [1:0] sclk_sync_r;
    logic [1:0] cs_sync_r;
    logic [1:0] mosi_sync_r;
    logic       sclk_prev_r;
    logic       cs_active_r;
    logic [2:0] bit_cnt_r;
    logic [6:0] rx_shift_r;
    logic [7:0] rx_byte_r;
    logic       byte_done_r;
    logic [7:0] tx_shift_r;

    logic sclk_rise_s;
    logic sclk_fall_s;

    // Edge strobes on the synchronised SPI clock.
    always_comb begin
        sclk_rise_s = 1'b0;
        sclk_fall_s = 1'b0;
        if (cs_active_r) begin
            sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
            sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
        end else begin
            sclk_rise_s = 1'b0;
            sclk_fall_s = 1'b0;
        end
    end

    // Synchronisers, bit counter, RX assembly and TX shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= 2'b00;
            cs_sync_r   <= 2'b11;
            mosi_sync_r <= 2'b00;
            sclk_prev_r <= 1'b0;
            cs_active_r <= 1'b0;
            bit_cnt_r   <= 3'd0;
            rx_shift_r  <= 7'd0;
            rx_byte_r   <= 8'd0;
            byte_done_r <= 1'b0;
            tx_shift_r  <= 8'd0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
            sclk_prev_r <= sclk_sync_r[1];
            cs_active_r <= ~cs_sync_r[1];
            byte_done_r <= 1'b0;
            if (!cs_active_r) begin
                bit_cnt_r  <= 3'd0;
                tx_shift_r <= 8'd0;
            end else begin
                if (sclk_rise_s) begin
                    rx_shift_r <= {rx_shift_r[5:0], mosi_sync_r[1]};
                    bit_cnt_r  <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        byte_done_r <= 1'b1;
                        rx_byte_r   <= {rx_shift_r, mosi_sync_r[1]};
                    end
                end
                // A load lands just after the 8th rise, when bit_cnt is 0,
                // so the following fall keeps the new MSB on MISO.
                if (load) begin
                    tx_shift_r <= tx_byte;
                end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
                    tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                end
            end
        end
    end

    assign byte_done   = byte_done_r;
    assign rx_byte     = rx_byte_r;
    assign cs_active   = cs_active_r;
    assign spi_miso    = tx_shift_r[7];
    assign spi_miso_oe = cs_active_r;

endmodule

// File: rtl/spi_wb_bridge_rw.sv
// SPI mode-0 slave to Wishbone classic master bridge: frame decoding,
// auto-incrementing address, WB cycle engine with timeout, read buffering.
`timescale 1ns/1ps
module spi_wb_bridge_rw
    import spi_wb_bridge_rw_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 1,
    parameter int WB_TIMEOUT = 255
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic [8*ADDR_BYTES-1:0]   wb_adr_o,
    output logic [8*DATA_BYTES-1:0]   wb_dat_o,
    input  logic [8*DATA_BYTES-1:0]   wb_dat_i,
    output logic                      wb_we_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    input  logic                      wb_ack_i,
    output logic                      err_overrun,
    output logic                      err_timeout
);

    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int TMO_W  = $clog2(WB_TIMEOUT + 1);
    localparam logic [7:0]       ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]       DATA_LAST = 8'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(WB_TIMEOUT - 1);

    // Shifter interface
    logic       byte_done_s;
    logic [7:0] rx_byte_s;
    logic       cs_active_s;
    logic       load_s;
    logic [7:0] tx_byte_s;

    // Frame state
    frame_state_t      frame_r;
    logic [7:0]        cmd_r;
    logic [7:0]        byte_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wr_buf_r;
    logic [DATA_W-1:0] tx_grp_r;

    // WB state
    wb_state_t         wb_state_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              cyc_r;
    logic              we_r;
    logic [ADDR_W-1:0] adr_r;
    logic [DATA_W-1:0] dat_r;
    logic [DATA_W-1:0] rd_buf_r;
    logic              rd_valid_r;
    logic              rd_discard_r;
    logic              rd_req_r;
    logic [ADDR_W-1:0] rd_req_adr_r;
    logic              err_overrun_r;
    logic              err_timeout_r;

    // Decoded strobes
    logic                   byte_ev_s;
    logic [ADDR_W+7:0]      addr_cat_s;
    logic [ADDR_W-1:0]      addr_in_s;
    logic [ADDR_W-1:0]      addr_inc_s;
    logic [DATA_W+7:0]      wr_cat_s;
    logic [DATA_W-1:0]      wr_word_s;
    logic                   rd_first_s;
    logic                   wr_group_s;
    logic                   load_pt_s;
    logic                   load_mid_s;
    logic                   rd_want_s;
    logic                   rd_go_s;
    logic [ADDR_W-1:0]      rd_adr_s;
    logic [DATA_W-1:0]      grp_word_s;
    logic                   wb_idle_s;
    logic                   overrun_s;
    logic                   tmo_hit_s;
    logic                   keep_rd_s;

    spi_wb_bridge_rw_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .load        (load_s),
        .tx_byte     (tx_byte_s),
        .byte_done   (byte_done_s),
        .rx_byte     (rx_byte_s),
        .cs_active   (cs_active_s),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    // Decode byte events into WB requests, TX loads and error conditions.
    always_comb begin
        byte_ev_s  = byte_done_s & cs_active_s;
        addr_cat_s = {addr_r, rx_byte_s};
        addr_in_s  = addr_cat_s[ADDR_W-1:0];
        addr_inc_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        wr_cat_s   = {wr_buf_r, rx_byte_s};
        wr_word_s  = wr_cat_s[DATA_W-1:0];
        wb_idle_s  = (wb_state_r == WB_IDLE);

        rd_first_s = byte_ev_s && (frame_r == F_ADDR) && (byte_cnt_r == ADDR_LAST)
                     && (cmd_r == CMD_READ);
        wr_group_s = byte_ev_s && (frame_r == F_WDATA) && (byte_cnt_r == DATA_LAST);
        load_pt_s  = byte_ev_s && ((frame_r == F_DUMMY) ||
                     ((frame_r == F_RDATA) && (byte_cnt_r == DATA_LAST)));
        load_mid_s = byte_ev_s && (frame_r == F_RDATA) && (byte_cnt_r != DATA_LAST);
        rd_want_s  = rd_first_s | load_pt_s;
        rd_go_s    = wb_idle_s && !wr_group_s && (rd_want_s || rd_req_r);

        if (rd_first_s) begin
            rd_adr_s = addr_in_s;
        end else if (load_pt_s) begin
            rd_adr_s = addr_inc_s;
        end else begin
            rd_adr_s = rd_req_adr_r;
        end

        if (rd_valid_r) begin
            grp_word_s = rd_buf_r;
        end else begin
            grp_word_s = {DATA_BYTES{RD_FILL}};
        end

        load_s = load_pt_s | load_mid_s;
        if (load_pt_s) begin
            tx_byte_s = grp_word_s[DATA_W-1 -: 8];
        end else begin
            tx_byte_s = tx_grp_r[DATA_W-1 -: 8];
        end

        overrun_s = (wr_group_s && !wb_idle_s) || (load_pt_s && !rd_valid_r);
        tmo_hit_s = !wb_idle_s && !wb_ack_i && (tmo_cnt_r == TMO_LAST);
        // Data acked at its own load point is already too late for that group.
        keep_rd_s = (wb_state_r == WB_READ) && wb_ack_i && !rd_discard_r
                    && cs_active_s && !load_pt_s;
    end

    // Frame FSM: command, address assembly, data groups, TX group buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_r    <= F_CMD;
            cmd_r      <= 8'd0;
            byte_cnt_r <= 8'd0;
            addr_r     <= '0;
            wr_buf_r   <= '0;
            tx_grp_r   <= '0;
        end else if (!cs_active_s) begin
            frame_r    <= F_CMD;
            byte_cnt_r <= 8'd0;
        end else if (byte_done_s) begin
            case (frame_r)
                F_CMD: begin
                    cmd_r      <= rx_byte_s;
                    byte_cnt_r <= 8'd0;
                    if ((rx_byte_s == CMD_WRITE) || (rx_byte_s == CMD_READ)) begin
                        frame_r <= F_ADDR;
                    end else begin
                        frame_r <= F_IGNORE;
                    end
                end
                F_ADDR: begin
                    addr_r <= addr_in_s;
                    if (byte_cnt_r == ADDR_LAST) begin
                        byte_cnt_r <= 8'd0;
                        frame_r    <= (cmd_r == CMD_WRITE) ? F_WDATA : F_DUMMY;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                    end
                end
                F_WDATA: begin
                    wr_buf_r <= wr_word_s;
                    if (byte_cnt_r == DATA_LAST) begin
                        byte_cnt_r <= 8'd0;
                        addr_r     <= addr_inc_s;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                    end
                end
                F_DUMMY: begin
                    frame_r    <= F_RDATA;
                    byte_cnt_r <= 8'd0;
                    addr_r     <= addr_inc_s;
                    tx_grp_r   <= grp_word_s << 4'd8;
                end
                F_RDATA: begin
                    if (byte_cnt_r == DATA_LAST) begin
                        byte_cnt_r <= 8'd0;
                        addr_r     <= addr_inc_s;
                        tx_grp_r   <= grp_word_s << 4'd8;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                        tx_grp_r   <= tx_grp_r << 4'd8;
                    end
                end
                F_IGNORE: begin
                    frame_r <= F_IGNORE;
                end
                default: begin
                    frame_r    <= F_CMD;
                    byte_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // WB FSM: cycle issue, ack/timeout handling, read buffer and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_state_r    <= WB_IDLE;
            tmo_cnt_r     <= '0;
            cyc_r         <= 1'b0;
            we_r          <= 1'b0;
            adr_r         <= '0;
            dat_r         <= '0;
            rd_buf_r      <= '0;
            rd_valid_r    <= 1'b0;
            rd_discard_r  <= 1'b0;
            rd_req_r      <= 1'b0;
            rd_req_adr_r  <= '0;
            err_overrun_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            err_overrun_r <= overrun_s;
            err_timeout_r <= tmo_hit_s;

            case (wb_state_r)
                WB_IDLE: begin
                    tmo_cnt_r <= '0;
                    if (wr_group_s) begin
                        cyc_r      <= 1'b1;
                        we_r       <= 1'b1;
                        adr_r      <= addr_r;
                        dat_r      <= wr_word_s;
                        wb_state_r <= WB_WRITE;
                    end else if (rd_go_s) begin
                        cyc_r      <= 1'b1;
                        we_r       <= 1'b0;
                        adr_r      <= rd_adr_s;
                        wb_state_r <= WB_READ;
                    end else begin
                        wb_state_r <= WB_IDLE;
                    end
                end
                WB_WRITE, WB_READ: begin
                    if (wb_ack_i || tmo_hit_s) begin
                        cyc_r      <= 1'b0;
                        we_r       <= 1'b0;
                        tmo_cnt_r  <= '0;
                        wb_state_r <= WB_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cyc_r      <= 1'b0;
                    we_r       <= 1'b0;
                    tmo_cnt_r  <= '0;
                    wb_state_r <= WB_IDLE;
                end
            endcase

            // Deferred read request when a load point finds the bus busy.
            if (!cs_active_s) begin
                rd_req_r <= 1'b0;
            end else if (rd_go_s) begin
                rd_req_r <= 1'b0;
            end else if (rd_want_s) begin
                rd_req_r     <= 1'b1;
                rd_req_adr_r <= rd_adr_s;
            end

            if (keep_rd_s) begin
                rd_buf_r <= wb_dat_i;
            end

            if (!cs_active_s) begin
                rd_valid_r <= 1'b0;
            end else if (keep_rd_s) begin
                rd_valid_r <= 1'b1;
            end else if (load_pt_s) begin
                rd_valid_r <= 1'b0;
            end else if ((wb_state_r == WB_READ) && tmo_hit_s) begin
                rd_valid_r <= 1'b0;
            end

            // A read that missed its load point or outlived its frame is dropped.
            if ((wb_state_r == WB_READ) && (wb_ack_i || tmo_hit_s)) begin
                rd_discard_r <= 1'b0;
            end else if ((wb_state_r == WB_READ) &&
                         (!cs_active_s || (load_pt_s && !rd_valid_r))) begin
                rd_discard_r <= 1'b1;
            end
        end
    end

    assign wb_cyc_o    = cyc_r;
    assign wb_stb_o    = cyc_r;
    assign wb_we_o     = we_r;
    assign wb_adr_o    = adr_r;
    assign wb_dat_o    = dat_r;
    assign err_overrun = err_overrun_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_spi_wb_bridge_rw.sv
// Directed bench for spi_wb_bridge_rw: SPI host model, WB slave model, checks.
`timescale 1ns/1ps
module tb_spi_wb_bridge_rw;

    logic        clk;
    logic        rst;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        err_overrun;
    logic        err_timeout;

    spi_wb_bridge_rw #(
        .ADDR_BYTES (2),
        .DATA_BYTES (1),
        .WB_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (wb_ack_i),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    int half_ns = 40;
    logic [7:0] tx_buf [0:15];
    logic [7:0] rx_buf [0:15];
    logic       oe_at_start;

    // WB slave model state and logs
    int          ack_delay = 1;
    int          wait_cnt = 0;
    logic [7:0]  rd_q [$];
    logic [15:0] log_adr [$];
    logic [7:0]  log_dat [$];
    logic        log_we [$];
    int          cyc_rises = 0;
    int          cyc_run = 0;
    int          cyc_len = 0;
    logic        cyc_prev = 1'b0;
    int          n_ovr = 0;
    int          n_tmo = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
        tx_buf[3] = b3; tx_buf[4] = b4; tx_buf[5] = b5;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int b = 7; b >= 0; b--) begin
            spi_mosi = tx[b];
            #(half_ns);
            spi_sclk = 1'b1;
            rx[b] = spi_miso;
            #(half_ns);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input bit release_cs);
        logic [7:0] r;
        @(posedge clk);
        #2;
        spi_cs_n = 1'b0;
        #(half_ns);
        oe_at_start = spi_miso_oe;
        for (int i = 0; i < n; i++) begin
            spi_byte(tx_buf[i], r);
            rx_buf[i] = r;
        end
        #(half_ns);
        if (release_cs) begin
            spi_cs_n = 1'b1;
            #300;
        end
    endtask

    // WB slave with programmable ack latency, plus bus/error monitors.
    always @(negedge clk) begin
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            wait_cnt++;
            if ((ack_delay != 0) && (wait_cnt >= ack_delay)) begin
                wb_ack_i = 1'b1;
                wait_cnt = 0;
                log_adr.push_back(wb_adr_o);
                log_dat.push_back(wb_dat_o);
                log_we.push_back(wb_we_o);
                if (!wb_we_o) begin
                    if (rd_q.size() > 0) wb_dat_i = rd_q.pop_front();
                    else wb_dat_i = 8'h00;
                end
            end
        end else begin
            wait_cnt = 0;
        end
        if (wb_cyc_o && !cyc_prev) cyc_rises++;
        if (wb_cyc_o) begin
            cyc_run++;
        end else if (cyc_prev) begin
            cyc_len = cyc_run;
            cyc_run = 0;
        end
        cyc_prev = wb_cyc_o;
        if (err_overrun) n_ovr++;
        if (err_timeout) n_tmo++;
    end

    initial begin
        int base;
        int c0;
        int o0;
        int t0;
        int cnt;

        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        wb_ack_i = 1'b0; wb_dat_i = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_eq("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check_eq("rst_we", {31'd0, wb_we_o}, 32'd0);
        check_eq("rst_adr", {16'd0, wb_adr_o}, 32'd0);
        check_eq("rst_dat", {24'd0, wb_dat_o}, 32'd0);
        check_eq("rst_miso", {30'd0, spi_miso, spi_miso_oe}, 32'd0);
        check_eq("rst_err", {30'd0, err_overrun, err_timeout}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single write 0x1234 = 0x5A
        ack_delay = 1;
        base = log_adr.size();
        set_bytes(8'h01, 8'h12, 8'h34, 8'h5A, 8'h00, 8'h00);
        spi_frame(4, 1'b1);
        check_eq("t1_oe_active", {31'd0, oe_at_start}, 32'd1);
        check_eq("t1_oe_idle", {31'd0, spi_miso_oe}, 32'd0);
        check_eq("t1_count", log_adr.size() - base, 32'd1);
        if (log_adr.size() > base) begin
            check_eq("t1_adr", {16'd0, log_adr[base]}, 32'h1234);
            check_eq("t1_dat", {24'd0, log_dat[base]}, 32'h5A);
            check_eq("t1_we", {31'd0, log_we[base]}, 32'd1);
        end

        // 2: burst write from 0x0010, ack after 2 clk
        ack_delay = 2;
        base = log_adr.size();
        set_bytes(8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC);
        spi_frame(6, 1'b1);
        check_eq("t2_count", log_adr.size() - base, 32'd3);
        if (log_adr.size() >= base + 3) begin
            check_eq("t2_adr0", {16'd0, log_adr[base]}, 32'h0010);
            check_eq("t2_dat0", {24'd0, log_dat[base]}, 32'hAA);
            check_eq("t2_adr1", {16'd0, log_adr[base+1]}, 32'h0011);
            check_eq("t2_dat1", {24'd0, log_dat[base+1]}, 32'hBB);
            check_eq("t2_adr2", {16'd0, log_adr[base+2]}, 32'h0012);
            check_eq("t2_dat2", {24'd0, log_dat[base+2]}, 32'hCC);
        end
        check_eq("t12_no_err", n_ovr + n_tmo, 32'd0);

        // 3: read 0x0020, slave returns 0x3C after 3 clk
        ack_delay = 3;
        rd_q.push_back(8'h3C);
        base = log_adr.size();
        set_bytes(8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        spi_frame(5, 1'b1);
        if (log_adr.size() > base) begin
            check_eq("t3_adr", {16'd0, log_adr[base]}, 32'h0020);
            check_eq("t3_we", {31'd0, log_we[base]}, 32'd0);
        end else begin
            check_eq("t3_count", log_adr.size() - base, 32'd1);
        end
        check_eq("t3_miso_hdr", {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]}, 32'd0);
        check_eq("t3_miso_data", {24'd0, rx_buf[4]}, 32'h3C);

        // 4: read burst across the address wrap
        ack_delay = 1;
        rd_q.delete();
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        base = log_adr.size();
        set_bytes(8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        spi_frame(6, 1'b1);
        check_eq("t4_count_ge2", {31'd0, log_adr.size() >= base + 2}, 32'd1);
        if (log_adr.size() >= base + 2) begin
            check_eq("t4_adr0", {16'd0, log_adr[base]}, 32'hFFFF);
            check_eq("t4_adr1", {16'd0, log_adr[base+1]}, 32'h0000);
        end
        check_eq("t4_miso0", {24'd0, rx_buf[4]}, 32'h11);
        check_eq("t4_miso1", {24'd0, rx_buf[5]}, 32'h22);
        check_eq("t34_no_err", n_ovr + n_tmo, 32'd0);

        // 5: read with no ack, slow SCLK: every read times out, data is fill
        half_ns = 160;
        ack_delay = 0;
        o0 = n_ovr;
        t0 = n_tmo;
        set_bytes(8'h02, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00);
        spi_frame(5, 1'b1);
        check_eq("t5_cyc_len", cyc_len, 32'd16);
        check_eq("t5_timeouts", n_tmo - t0, 32'd3);
        check_eq("t5_overruns", n_ovr - o0, 32'd2);
        check_eq("t5_miso_fill", {24'd0, rx_buf[4]}, 32'hEE);
        check_eq("t5_cyc_idle", {31'd0, wb_cyc_o}, 32'd0);
        half_ns = 40;

        // 6: aborted frame, unknown command, reset mid cycle, then recovery
        ack_delay = 1;
        c0 = cyc_rises;
        set_bytes(8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
        spi_frame(2, 1'b1);
        set_bytes(8'h7F, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00);
        spi_frame(4, 1'b1);
        check_eq("t6_no_cycles", cyc_rises - c0, 32'd0);

        ack_delay = 0;
        base = log_adr.size();
        o0 = n_ovr;
        t0 = n_tmo;
        set_bytes(8'h01, 8'h00, 8'h05, 8'h77, 8'h00, 8'h00);
        spi_frame(4, 1'b0);
        cnt = 0;
        while (!wb_cyc_o && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("t6_cyc_up", {31'd0, wb_cyc_o}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_eq("t6_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        spi_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("t6_rst_no_pulse", (n_ovr - o0) + (n_tmo - t0), 32'd0);
        check_eq("t6_rst_no_ack", log_adr.size() - base, 32'd0);

        ack_delay = 1;
        set_bytes(8'h01, 8'h00, 8'h01, 8'h55, 8'h00, 8'h00);
        spi_frame(4, 1'b1);
        check_eq("t6_recover_count", log_adr.size() - base, 32'd1);
        if (log_adr.size() > base) begin
            check_eq("t6_recover_adr", {16'd0, log_adr[base]}, 32'h0001);
            check_eq("t6_recover_dat", {24'd0, log_dat[base]}, 32'h55);
            check_eq("t6_recover_we", {31'd0, log_we[base]}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
